// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch slice.
// The entry layout in the fetch buffer is {pc, insn}, with pc in the upper bits.
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif
`ifndef ISIZE
`define ISIZE 16
`endif

package fetch_pkg;

    localparam int FETCH_ADDR_W    = `MEM_SPACE;
    localparam int FETCH_INSN_W    = `ISIZE;
    localparam int FETCH_BUF_DEPTH = 2;
    localparam int FETCH_RESET_PC  = 0;

    // Padding word the memory returns past the end of a program; doubles as NOP.
    localparam logic [15:0] FETCH_PAD_WORD = 16'h0000;

    function automatic int entry_w(input int aw, input int iw);
        return aw + iw;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO holding fetched {pc, insn} entries between memory return and decode.
// Flush wins over push and pop on the same edge.
module fetch_buf #(
    parameter int DEPTH = 2,
    parameter int W     = 24,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output logic [W-1:0]  head_data
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign do_pop     = pop & head_valid;
    assign do_push    = push & ((count != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push & ~flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// IF-stage sequencer: owns the PC, tracks the one-cycle memory read, buffers returns.
// Optional HALT_ON_ZERO_EN stops fetching when a padding (all-zero) word comes back.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = FETCH_ADDR_W,
    parameter int INSN_W    = FETCH_INSN_W,
    parameter int BUF_DEPTH = FETCH_BUF_DEPTH,
    parameter int RESET_PC  = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INSN_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_valid,
    output logic [INSN_W-1:0] fetch_insn,
    output logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_ready,
    output logic              halted
);
    localparam int ENTRY_W = entry_w(ADDR_W, INSN_W);
    localparam int CW      = $clog2(BUF_DEPTH + 1);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_p1;
    logic               vld_p1;
    logic               halted_q;
    logic               pop;
    logic               issue;
    logic               capture;
    logic               halt_now;
    logic               push;
    logic [CW:0]        credit_used;
    logic [CW-1:0]      count;
    logic               head_valid;
    logic [ENTRY_W-1:0] head_entry;

    assign imem_addr = pc;
    assign pop       = fetch_valid & fetch_ready;

    // Slots already spoken for: buffered entries plus the word in flight, less
    // the entry leaving this edge. Issuing only below depth makes overflow impossible.
    assign credit_used = (CW+1)'(count) + (CW+1)'(vld_p1) - (CW+1)'(pop);
    assign issue       = (credit_used < (CW+1)'(BUF_DEPTH)) & ~redirect_valid & ~halted_q;
    assign capture     = vld_p1 & ~redirect_valid & ~halted_q;

    // ---- stage p0: address issue ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= ADDR_W'(RESET_PC);
            vld_p1 <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            vld_p1 <= 1'b0;
        end else if (issue) begin
            pc     <= pc + ADDR_W'(1);
            vld_p1 <= 1'b1;
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) pc_p1 <= pc;
    end

    // ---- stage p1: memory return, halt detection, buffer push ----
`ifdef HALT_ON_ZERO_EN
    assign halt_now = capture & (imem_data == INSN_W'(FETCH_PAD_WORD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            halted_q <= 1'b0;
        end else if (halt_now) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halt_now = 1'b0;
    assign halted_q = 1'b0;
`endif

    assign push   = capture & ~halt_now;
    assign halted = halted_q;

    fetch_buf #(
        .DEPTH (BUF_DEPTH),
        .W     (ENTRY_W),
        .CW    (CW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  ({pc_p1, imem_data}),
        .pop        (pop),
        .count      (count),
        .head_valid (head_valid),
        .head_data  (head_entry)
    );

    // ---- stage p2: decode handoff ----
    // Head fields are forced to zero when empty so reset shows clean outputs
    // without resetting the storage itself.
    assign fetch_valid = head_valid;
    assign fetch_insn  = head_valid ? head_entry[INSN_W-1:0] : '0;
    assign fetch_pc    = head_valid ? head_entry[ENTRY_W-1 -: ADDR_W] : '0;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized ready/redirect traffic,
// with a program-order reference model feeding a scoreboard queue.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        fetch_valid;
    logic [15:0] fetch_insn;
    logic [7:0]  fetch_pc;
    logic        fetch_ready;
    logic        halted;

    logic [15:0] mem [256];
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;
    logic [7:0]  model_pc;
    bit          model_stop;
    int          tests = 0;
    int          fails = 0;
    int          deliv = 0;
    int          d0;
    logic [7:0]  held_addr;
    bit          stall_seen = 1'b0;
    logic [7:0]  stall_pc;
    logic [15:0] stall_insn;

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_valid    (fetch_valid),
        .fetch_insn     (fetch_insn),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Registered-read instruction memory
    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: decode should see consecutive addresses from the last
    // restart point, each paired with that memory word, until a padding word
    // when the halt feature is built in.
    task automatic model_fill();
        while (exp_q.size() < 16 && !model_stop) begin
`ifdef HALT_ON_ZERO_EN
            if (mem[model_pc] == 16'h0000) begin
                model_stop = 1'b1;
            end else begin
                exp_q.push_back({model_pc, mem[model_pc]});
                model_pc = model_pc + 8'd1;
            end
`else
            exp_q.push_back({model_pc, mem[model_pc]});
            model_pc = model_pc + 8'd1;
`endif
        end
    endtask

    task automatic model_restart(input logic [7:0] start);
        exp_q.delete();
        model_pc   = start;
        model_stop = 1'b0;
        model_fill();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [7:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
        model_restart(target);
    endtask

    // Monitor: every completed handshake is matched against the model queue
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_seen && fetch_valid) begin
                chk("hold_pc", {24'd0, fetch_pc}, {24'd0, stall_pc});
                chk("hold_insn", {16'd0, fetch_insn}, {16'd0, stall_insn});
            end
            if (fetch_valid && fetch_ready) begin
                deliv++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_delivery: got pc 0x%0h insn 0x%0h, expected no delivery",
                             fetch_pc, fetch_insn);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_pc", {24'd0, fetch_pc}, {24'd0, mon_e[23:16]});
                    chk("sb_insn", {16'd0, fetch_insn}, {16'd0, mon_e[15:0]});
                    model_fill();
                end
            end
            stall_seen = fetch_valid && !fetch_ready;
            stall_pc   = fetch_pc;
            stall_insn = fetch_insn;
        end else begin
            stall_seen = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        fetch_ready    = 1'b1;
        #3;
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_insn", {16'd0, fetch_insn}, 32'd0);
        chk("rst_pc", {24'd0, fetch_pc}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        // Stream from reset
        repeat (2) tick();
        rst = 1'b0;
        model_restart(8'h00);
        tick();
        chk("first_bubble", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("first_valid", {31'd0, fetch_valid}, 32'd1);
        chk("first_pc", {24'd0, fetch_pc}, 32'h00);
        chk("first_insn", {16'd0, fetch_insn}, 32'h1000);
        d0 = deliv;
        repeat (20) tick();
        chk("stream_rate", deliv - d0, 32'd20);

        // Backpressure
        fetch_ready = 1'b0;
        repeat (3) tick();
        held_addr = imem_addr;
        repeat (2) tick();
        chk("bp_valid", {31'd0, fetch_valid}, 32'd1);
        chk("bp_addr_hold", {24'd0, imem_addr}, {24'd0, held_addr});
        chk("bp_two_held", {24'd0, imem_addr}, {24'd0, 8'(fetch_pc + 8'd2)});
        fetch_ready = 1'b1;
        d0 = deliv;
        repeat (10) tick();
        chk("bp_resume_rate", deliv - d0, 32'd10);

        // Redirect while streaming with a fetch in flight
        do_redirect(8'h40);
        chk("redir_bubble0", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("redir_bubble1", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("redir_valid", {31'd0, fetch_valid}, 32'd1);
        chk("redir_pc", {24'd0, fetch_pc}, 32'h40);
        chk("redir_insn", {16'd0, fetch_insn}, 32'h1040);
        repeat (4) tick();

        // Redirect with a full buffer
        fetch_ready = 1'b0;
        repeat (4) tick();
        do_redirect(8'h80);
        fetch_ready = 1'b1;
        repeat (2) tick();
        chk("redir_full_pc", {24'd0, fetch_pc}, 32'h80);
        repeat (3) tick();

        // Address wrap
        do_redirect(8'hFF);
        repeat (2) tick();
        chk("wrap_pc_ff", {24'd0, fetch_pc}, 32'hFF);
        chk("wrap_insn_ff", {16'd0, fetch_insn}, 32'h10FF);
        tick();
        chk("wrap_pc_00", {24'd0, fetch_pc}, 32'h00);
        chk("wrap_insn_00", {16'd0, fetch_insn}, 32'h1000);

        // Back-to-back redirects: the later one wins
        redirect_valid = 1'b1;
        redirect_pc    = 8'h20;
        tick();
        redirect_pc    = 8'h30;
        tick();
        redirect_valid = 1'b0;
        model_restart(8'h30);
        chk("b2b_bubble", {31'd0, fetch_valid}, 32'd0);
        repeat (2) tick();
        chk("b2b_pc", {24'd0, fetch_pc}, 32'h30);

        // Random ready and redirect traffic
        for (int c = 0; c < 400; c++) begin
            fetch_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 29) == 0) do_redirect(8'($urandom_range(0, 255)));
            else tick();
        end
        fetch_ready = 1'b1;
        repeat (6) tick();

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("arst_addr", {24'd0, imem_addr}, 32'd0);
        chk("arst_insn", {16'd0, fetch_insn}, 32'd0);
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        model_restart(8'h00);
        repeat (2) tick();
        chk("arst_restart_pc", {24'd0, fetch_pc}, 32'h00);
        chk("arst_restart_valid", {31'd0, fetch_valid}, 32'd1);
        repeat (4) tick();

`ifdef HALT_ON_ZERO_EN
        // Halt on padding word
        rst    = 1'b1;
        mem[3] = 16'h0000;
        exp_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        model_restart(8'h00);
        d0 = deliv;
        repeat (15) tick();
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_valid", {31'd0, fetch_valid}, 32'd0);
        chk("halt_count", deliv - d0, 32'd3);
        do_redirect(8'h10);
        chk("halt_clear", {31'd0, halted}, 32'd0);
        repeat (2) tick();
        chk("halt_redir_pc", {24'd0, fetch_pc}, 32'h10);
        mem[3] = 16'h1003;
        repeat (4) tick();
`else
        chk("halted_tied0", {31'd0, halted}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
